hazard_control: RTL and testbench

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/hazard_control.sv | 126 ++++++++++++
 tb/tb_hazard_control.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control.sv
// Pipeline hazard unit: memory-wait FSM, load-use/RAW decode stalls, jump flush, operand forwarding.
// Optional operand forwarding is enabled by defining HAZARD_FORWARD_EN.
module hazard_control (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemAccessM,
  input  logic        MemReadyM,
  input  logic        JumpD,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic [31:0] StallCount,
  output logic        MemTimeout
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERROR    = 2'd2;

  logic [1:0] state;
  logic [7:0] waitCount;
  logic       memStall;
  logic       decodeStall;
  logic [1:0] fwdA;
  logic [1:0] fwdB;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic regMatch(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst == src) && (src != 5'd0);
  endfunction

  always_comb begin
    memStall = (state == ERROR) || (MemAccessM && !MemReadyM);
    MemTimeout = (state == ERROR);
  end

`ifdef HAZARD_FORWARD_EN
  always_comb begin
    decodeStall = MemtoRegE && (regMatch(RegWriteE, WriteRegE, RsD) ||
                                regMatch(RegWriteE, WriteRegE, RtD));
    fwdA = regMatch(RegWriteM, WriteRegM, RsE) ? 2'b10 :
           regMatch(RegWriteW, WriteRegW, RsE) ? 2'b01 : 2'b00;
    fwdB = regMatch(RegWriteM, WriteRegM, RtE) ? 2'b10 :
           regMatch(RegWriteW, WriteRegW, RtE) ? 2'b01 : 2'b00;
  end
`else
  logic unusedFwdInputs;
  // Without bypass paths every in-flight E/M writer must retire first; W writes complete in time.
  always_comb begin
    decodeStall = regMatch(RegWriteE, WriteRegE, RsD) || regMatch(RegWriteE, WriteRegE, RtD) ||
                  regMatch(RegWriteM, WriteRegM, RsD) || regMatch(RegWriteM, WriteRegM, RtD);
    fwdA = 2'b00;
    fwdB = 2'b00;
    unusedFwdInputs = ^{RsE, RtE, WriteRegW, RegWriteW, MemtoRegE};
  end
`endif

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b1;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (reset_n) begin
      ForwardAE = fwdA;
      ForwardBE = fwdB;
      if (memStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (decodeStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b0;
      end else begin
        FlushD = JumpD;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      waitCount  <= '0;
      StallCount <= '0;
    end else begin
      if (StallF && (StallCount != '1)) StallCount <= StallCount + 32'd1;
      case (state)
        RUN: begin
          if (memStall) begin
            state     <= MEM_WAIT;
            waitCount <= '0;
          end
        end
        MEM_WAIT: begin
          if (MemReadyM) state <= RUN;
          else if (waitCount == 8'hFF) state <= ERROR;
          else waitCount <= waitCount + 8'd1;
        end
        ERROR:   state <= ERROR;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: directed scenarios plus randomized traffic vs a behavioural model.
module tb_hazard_control;

  logic        clock;
  logic        reset_n;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemAccessM, MemReadyM, JumpD;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCount;
  logic        MemTimeout;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit     mWaiting;
  bit     mError;
  int     mWaited;
  longint mStallCount;

  hazard_control dut (
    .clock(clock), .reset_n(reset_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemAccessM(MemAccessM), .MemReadyM(MemReadyM), .JumpD(JumpD),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCount(StallCount), .MemTimeout(MemTimeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  function automatic bit hits(input bit we, input logic [4:0] dst, input logic [4:0] src);
    return we && (src != 5'd0) && (dst == src);
  endfunction

  function automatic bit mMemStall();
    return mError || (MemAccessM && !MemReadyM);
  endfunction

  function automatic bit mDecStall();
`ifdef HAZARD_FORWARD_EN
    return MemtoRegE && (hits(RegWriteE, WriteRegE, RsD) || hits(RegWriteE, WriteRegE, RtD));
`else
    return hits(RegWriteE, WriteRegE, RsD) || hits(RegWriteE, WriteRegE, RtD) ||
           hits(RegWriteM, WriteRegM, RsD) || hits(RegWriteM, WriteRegM, RtD);
`endif
  endfunction

  function automatic logic [1:0] mFwd(input logic [4:0] src);
`ifdef HAZARD_FORWARD_EN
    if (hits(RegWriteM, WriteRegM, src)) return 2'b10;
    if (hits(RegWriteW, WriteRegW, src)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic logic [31:0] mCount();
    return (mStallCount > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : mStallCount[31:0];
  endfunction

  task automatic modelReset();
    mWaiting = 0; mError = 0; mWaited = 0; mStallCount = 0;
  endtask

  task automatic setIdle();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    MemAccessM = 0; MemReadyM = 1; JumpD = 0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    bit sF;
    sF = reset_n && (mMemStall() || mDecStall());
    @(posedge clock);
    if (!reset_n) modelReset();
    else begin
      if (sF) mStallCount++;
      if (!mError) begin
        if (mWaiting) begin
          if (MemReadyM) mWaiting = 0;
          else begin
            mWaited++;
            if (mWaited == 256) begin mError = 1; mWaiting = 0; end
          end
        end else if (MemAccessM && !MemReadyM) begin
          mWaiting = 1; mWaited = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    setIdle();
    MemAccessM = 1; MemReadyM = 0; JumpD = 1; MemtoRegE = 1; RegWriteE = 1; WriteRegE = 4; RsD = 4;
    RegWriteM = 1; WriteRegM = 6; RsE = 6; RtE = 6;
    reset_n = 0; modelReset();
    #2;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE} !== 10'b0000_01_0000) begin
      errors++;
      $display("FAIL reset outputs: got %b expected %b",
               {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE}, 10'b0000010000);
    end
    checks++;
    if (StallCount !== 32'd0 || MemTimeout !== 1'b0) begin
      errors++;
      $display("FAIL reset counters: got cnt=%0d to=%b expected cnt=0 to=0", StallCount, MemTimeout);
    end
    tick();
    setIdle();
    reset_n = 1;
    tick();
  endtask

  task automatic test_forwarding();
    setIdle();
    RegWriteM = 1; WriteRegM = 8; RsE = 8; RegWriteW = 1; WriteRegW = 8;
    #2;
    checks++;
`ifdef HAZARD_FORWARD_EN
    if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwdMpriority: got %b expected 10", ForwardAE); end
`else
    if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwdOffM: got %b expected 00", ForwardAE); end
`endif
    tick();
    WriteRegM = 0;
    #2;
    checks++;
`ifdef HAZARD_FORWARD_EN
    if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwdW: got %b expected 01", ForwardAE); end
`else
    if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwdOffW: got %b expected 00", ForwardAE); end
`endif
    tick();
    setIdle();
    RegWriteE = 1; WriteRegE = 3; RsD = 3; RsE = 3; RegWriteM = 1; WriteRegM = 3;
    #2;
    checks++;
`ifdef HAZARD_FORWARD_EN
    if (StallD !== 1'b0 || ForwardAE !== 2'b10) begin
      errors++; $display("FAIL rawFwdOn: got stallD=%b fwd=%b expected stallD=0 fwd=10", StallD, ForwardAE);
    end
`else
    if (StallD !== 1'b1 || ForwardAE !== 2'b00) begin
      errors++; $display("FAIL rawStall: got stallD=%b fwd=%b expected stallD=1 fwd=00", StallD, ForwardAE);
    end
`endif
    tick();
    RegWriteM = 0; WriteRegE = 0; RsD = 0;
    #2;
    checks++;
    if (StallD !== 1'b0) begin errors++; $display("FAIL reg0NoStall: got %b expected 0", StallD); end
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] base;
    setIdle();
    base = mCount();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5; RtD = 5; JumpD = 1;
    #2;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b110000) begin
      errors++;
      $display("FAIL loadUse: got %b expected 110000", {StallF, StallD, StallE, StallM, FlushD, FlushE});
    end
    tick();
    MemtoRegE = 0; RegWriteE = 0; WriteRegE = 0;
    #2;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b000011) begin
      errors++;
      $display("FAIL jumpAfterBubble: got %b expected 000011", {StallF, StallD, StallE, StallM, FlushD, FlushE});
    end
    tick();
    checks++;
    if (StallCount !== base + 32'd1) begin
      errors++; $display("FAIL loadUseCount: got %0d expected %0d", StallCount, base + 32'd1);
    end
  endtask

  task automatic test_mem_stall();
    logic [31:0] base;
    setIdle();
    base = mCount();
    MemAccessM = 1; MemReadyM = 0; JumpD = 1; MemtoRegE = 1; RegWriteE = 1; WriteRegE = 7; RsD = 7;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b111101) begin
        errors++;
        $display("FAIL memStall cycle %0d: got %b expected 111101", c, {StallF, StallD, StallE, StallM, FlushD, FlushE});
      end
      tick();
    end
    setIdle();
    MemAccessM = 1; MemReadyM = 1;
    #2;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushE} !== 5'b00001) begin
      errors++; $display("FAIL memReadyRelease: got %b expected 00001", {StallF, StallD, StallE, StallM, FlushE});
    end
    tick();
    setIdle();
    #2;
    checks++;
    if (StallCount !== base + 32'd3 || StallF !== 1'b0) begin
      errors++; $display("FAIL memStallCount: got %0d stallF=%b expected %0d stallF=0", StallCount, StallF, base + 32'd3);
    end
    tick();
  endtask

  task automatic test_timeout();
    setIdle();
    MemAccessM = 1; MemReadyM = 0;
    for (int c = 0; c < 256; c++) tick();
    #2;
    checks++;
    if (MemTimeout !== 1'b0) begin errors++; $display("FAIL timeoutEarly: got %b expected 0", MemTimeout); end
    tick();
    MemAccessM = 0; MemReadyM = 1; JumpD = 1;
    #2;
    checks++;
    if ({MemTimeout, StallF, StallD, StallE, StallM, FlushD, FlushE} !== 7'b1111101) begin
      errors++;
      $display("FAIL errorState: got %b expected 1111101", {MemTimeout, StallF, StallD, StallE, StallM, FlushD, FlushE});
    end
    tick(); tick();
    #2;
    checks++;
    if (MemTimeout !== 1'b1 || StallF !== 1'b1 || StallCount !== mCount()) begin
      errors++; $display("FAIL errorSticky: got to=%b stallF=%b cnt=%0d expected to=1 stallF=1 cnt=%0d",
                         MemTimeout, StallF, StallCount, mCount());
    end
    RegWriteM = 1; WriteRegM = 9; RsE = 9;
    reset_n = 0; modelReset();
    #2;
    checks++;
    if ({MemTimeout, StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE} !== 9'b000000100 || StallCount !== 32'd0) begin
      errors++;
      $display("FAIL errorReset: got %b cnt=%0d expected 000000100 cnt=0",
               {MemTimeout, StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE}, StallCount);
    end
    tick();
    setIdle();
    reset_n = 1;
    tick();
    #2;
    checks++;
    if (MemTimeout !== 1'b0 || StallF !== 1'b0 || StallCount !== 32'd0) begin
      errors++; $display("FAIL afterReset: got to=%b stallF=%b cnt=%0d expected 0 0 0", MemTimeout, StallF, StallCount);
    end
    tick();
  endtask

  task automatic test_random();
    logic [10:0] expVec, actVec;
    bit ms, ds;
    for (int i = 0; i < 400; i++) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3)); WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 2) == 0);
      MemAccessM = ($urandom_range(0, 3) == 0);
      MemReadyM = ($urandom_range(0, 2) != 0);
      JumpD = ($urandom_range(0, 2) == 0);
      #2;
      ms = mMemStall();
      ds = mDecStall();
      expVec = {ms || ds, ms || ds, ms, ms, JumpD && !ms && !ds, !(ds && !ms), mFwd(RsE), mFwd(RtE), mError};
      actVec = {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, MemTimeout};
      checks++;
      if (actVec !== expVec) begin
        errors++; $display("FAIL random outputs @%0d: got %b expected %b", i, actVec, expVec);
      end
      checks++;
      if (StallCount !== mCount()) begin
        errors++; $display("FAIL random StallCount @%0d: got %0d expected %0d", i, StallCount, mCount());
      end
      tick();
    end
  endtask

  initial begin
    setIdle();
    reset_n = 0;
    modelReset();
    #7;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_stall();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
